// File: rtl/nx1_vram_fetch.sv
// ---------------------------------------------------------------------------
// nx1_vram_fetch -- row fetch engine for the X1 text/attribute VRAM.
//
// On a START pulse the engine reads LEN consecutive bytes starting at SADR
// from port B of the 2K x 8 dual-port VRAM. The bytes pass through a small
// first-word-fall-through FIFO and go to the character/pixel serializer over
// a valid/ready handshake. DONE pulses once per completed row.
//
// Optional feature macro: NX1_VFETCH_ABORT_EN
//   When defined, adds the ABORT input. ABORT returns the engine to idle,
//   flushes the FIFO and drops any in-flight read. No DONE is produced.
//
// Ports:
//   CLK     in   1  single clock, also the VRAM port B clock
//   RST     in   1  synchronous active-high reset
//   START   in   1  one-cycle row request, honoured only when idle
//   SADR    in  11  row start address, sampled with START
//   LEN     in   7  row byte count (0..127), sampled with START
//   BUSY    out  1  engine is not idle
//   BA      out 11  VRAM port B address
//   BCS     out  1  VRAM port B chip select / read strobe
//   BWE     out  1  VRAM port B write enable (always 0)
//   BI      out  8  VRAM port B write data (always 0)
//   BO      in   8  VRAM port B read data, valid the cycle after BCS
//   DO      out  8  FIFO head byte, 8'h00 when empty
//   DVALID  out  1  FIFO not empty
//   DREADY  in   1  consumer accepts DO this cycle
//   DONE    out  1  one-cycle row-complete pulse
//   ABORT   in   1  row abort (only with NX1_VFETCH_ABORT_EN)
// ---------------------------------------------------------------------------
module nx1_vram_fetch #(
    parameter int def_FIFO_AW = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [10:0] SADR,
    input  logic [6:0]  LEN,
    output logic        BUSY,
    output logic [10:0] BA,
    output logic        BCS,
    output logic        BWE,
    output logic [7:0]  BI,
    input  logic [7:0]  BO,
    output logic [7:0]  DO,
    output logic        DVALID,
    input  logic        DREADY,
    output logic        DONE
`ifdef NX1_VFETCH_ABORT_EN
    ,
    input  logic        ABORT
`endif
);

    localparam int DEPTH = 1 << def_FIFO_AW;
    localparam logic [def_FIFO_AW+1:0] DEPTH_C = (def_FIFO_AW+2)'(DEPTH);
    localparam logic [def_FIFO_AW:0]   OCC_ONE = (def_FIFO_AW+1)'(1);
    localparam logic [def_FIFO_AW-1:0] PTR_ONE = def_FIFO_AW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN
    } state_e;

    state_e                 state_q, state_d;
    logic [10:0]            adr_q, adr_d;
    logic [6:0]             cnt_q, cnt_d;
    logic                   infl_q, infl_d;
    logic                   done_q, done_d;
    logic [def_FIFO_AW:0]   occ_q, occ_d;
    logic [def_FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [def_FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]             mem [DEPTH];

    logic                   abort;
    logic                   issue;
    logic                   push;
    logic                   pop;
    logic [def_FIFO_AW+1:0] occ_infl;

`ifdef NX1_VFETCH_ABORT_EN
    assign abort = ABORT;
`else
    assign abort = 1'b0;
`endif

    // Counting in-flight reads against occupancy reserves a FIFO slot for
    // every byte already requested from the VRAM, so the FIFO cannot overflow.
    assign occ_infl = {1'b0, occ_q} + {{(def_FIFO_AW+1){1'b0}}, infl_q};
    assign issue    = (state_q == S_FETCH) && (cnt_q != 7'd0) &&
                      (occ_infl < DEPTH_C) && !abort && !RST;

    // Read data arrives one cycle after the strobe, so the previous cycle's
    // issue is this cycle's push.
    assign push = infl_q;
    assign pop  = (occ_q != '0) && DREADY;

    always_comb begin
        // NOTE: every next-state signal gets a default first so that no path
        // through the case statement leaves one unassigned and infers a latch.
        state_d  = state_q;
        adr_d    = adr_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        infl_d   = issue;
        occ_d    = occ_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        unique case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase

        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    if (LEN != 7'd0) begin
                        adr_d   = SADR;
                        cnt_d   = LEN;
                        state_d = S_FETCH;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                if (issue) begin
                    adr_d = adr_q + 11'd1;   // wraps 2047 -> 0
                    cnt_d = cnt_q - 7'd1;
                    if (cnt_q == 7'd1) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Decided on next-cycle values so DONE rises in the same cycle
                // that BUSY falls.
                if ((occ_d == '0) && !infl_d) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d  = S_IDLE;
            adr_d    = '0;
            cnt_d    = '0;
            done_d   = 1'b0;
            infl_d   = 1'b0;
            occ_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (RST) begin
            state_q  <= S_IDLE;
            adr_q    <= '0;
            cnt_q    <= '0;
            infl_q   <= 1'b0;
            done_q   <= 1'b0;
            occ_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            cnt_q    <= cnt_d;
            infl_q   <= infl_d;
            done_q   <= done_d;
            occ_q    <= occ_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: the FIFO storage is deliberately not reset; occupancy and the
    // pointers are, and DO is masked while empty, so stale contents are
    // never observable.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_q] <= BO;
        end
    end

    assign BUSY   = (state_q != S_IDLE);
    assign BA     = adr_q;
    assign BCS    = issue;
    assign BWE    = 1'b0;
    assign BI     = 8'h00;
    assign DVALID = (occ_q != '0);
    assign DO     = DVALID ? mem[rd_ptr_q] : 8'h00;
    assign DONE   = done_q;

endmodule

// File: doc/nx1_vram_fetch.md
# nx1_vram_fetch

Row fetch engine for the X1 text/attribute VRAM. On a start pulse from the CRTC timing logic it reads a run of consecutive bytes from the read port (port B) of the 2K×8 dual-port VRAM. It buffers them in a small first-word-fall-through FIFO and hands them to the character/pixel serializer over a valid/ready handshake. It is the stage directly downstream of the 2K×8 VRAM, driving that RAM's port B.

## Interface

Parameters:
- def_FIFO_AW, default 3: FIFO address width; depth = 2^def_FIFO_AW entries (8).

Ports:
- CLK, in, 1: single clock; also drives VRAM port B clock (BCLK).
- RST, in, 1: reset, synchronous, active-high.
- START, in, 1: one-cycle request to fetch a row; honoured only in IDLE.
- SADR, in, 11: row start address, sampled with START.
- LEN, in, 7: byte count, sampled with START; 0..127.
- BUSY, out, 1: high whenever state ≠ IDLE.
- BA, out, 11: VRAM port B address.
- BCS, out, 1: VRAM port B chip select (read strobe).
- BWE, out, 1: VRAM port B write enable; tied 0.
- BI, out, 8: VRAM port B write data; tied 8'h00.
- BO, in, 8: VRAM port B read data.
- DO, out, 8: FIFO head byte.
- DVALID, out, 1: FIFO not empty.
- DREADY, in, 1: consumer accepts DO this cycle.
- DONE, out, 1: one-cycle pulse marking row completion.
- ABORT, in, 1: present only with NX1_VFETCH_ABORT_EN.

## Operation

- **States.** IDLE, FETCH, DRAIN.
- **IDLE.**
  - START with LEN≠0: latch ADR←SADR and CNT←LEN, then go to FETCH.
  - START with LEN=0: pulse DONE next cycle and stay in IDLE.
- **FETCH.**
  - Each cycle where CNT≠0 and (OCC + INFL) < 2^def_FIFO_AW, issue a read: drive BCS=1 and BA=ADR, then ADR←ADR+1 and CNT←CNT−1.
  - OCC is the FIFO occupancy. INFL is 1 if a read was issued in the previous cycle.
  - After the read that takes CNT to 0, go to DRAIN.
- **DRAIN.** When OCC=0 and INFL=0, pulse DONE for one cycle and go to IDLE. DONE and BUSY=0 occur in the same cycle.
- **Address arithmetic.** 11-bit address, wraps 2047→0 with no error.
- **Read capture.** BO is written into the FIFO on the clock edge ending the cycle after BCS.
- **Pop.** A pop occurs when DVALID & DREADY. Push and pop in the same cycle leave OCC unchanged.
- **Ignored START.** START while BUSY is ignored; SADR and LEN are not resampled.
- **DO when empty.** DO reads 8'h00 while DVALID=0.
- **Reset (RST=1, synchronous).**
  - State←IDLE, OCC←0, INFL←0, CNT←0, ADR←0.
  - Outputs: BUSY=0, BCS=0, BA=0, DVALID=0, DO=8'h00, DONE=0.
  - Reset mid-row discards all buffered and in-flight data; no DONE is produced.

## Timing

- **Read latency.** START in cycle 0 → BCS=1 with BA=SADR in cycle 1 → BO captured at the end of cycle 2 → DVALID=1 in cycle 3.
- **Throughput.** One byte per cycle sustained while DREADY=1; the FIFO never stalls reads in that case.
- **Backpressure.** With DREADY=0, reads stop once OCC+INFL reaches depth. No byte is lost or duplicated.
- **Row latency.** With DREADY held 1, LEN=N gives DONE in cycle N+3.
- **Back-to-back rows.** START is accepted in the cycle DONE is high, since state is IDLE then.

## Configuration

- **NX1_VFETCH_ABORT_EN defined:**
  - Adds the ABORT input.
  - ABORT=1 in any state acts like RST on the state machine and FIFO: goes to IDLE, flushes the FIFO, and discards in-flight data.
  - BCS=0 in the same cycle.
  - No DONE pulse.
  - ABORT has priority over START in the same cycle.
- **Not defined:** no ABORT port. A row always runs to DONE unless RST is asserted.

## Test plan

- **Basic row.** VRAM preloaded with addr[7:0] at each address; START with SADR=0x010, LEN=5, DREADY=1 → DO sequence 0x10..0x14 on cycles 3..7, DONE in cycle 8, BUSY low from cycle 8.
- **Wrap-around.** SADR=0x7FE, LEN=4 → BA sequence 0x7FE, 0x7FF, 0x000, 0x001; four bytes delivered in order.
- **Backpressure.** LEN=20 with DREADY=0 for 30 cycles, then 1 → exactly 8 reads issued before the stall; all 20 bytes delivered in order after release with no gaps; DONE once.
- **Edge requests.** START with LEN=0 → DONE pulse next cycle, BCS never asserted. START during FETCH → ignored; the current row completes unchanged.
- **Reset mid-row.** RST while OCC=5 → next cycle DVALID=0, BUSY=0, BCS=0; no DONE pulse.
- **Abort (macro defined).** ABORT while in FETCH together with START → IDLE, FIFO empty, no DONE; a subsequent START fetches normally.
